// File: rtl/shift_reg_pkg.sv
// Shared types for the shift_reg_pipe block.
//   shift_mode_e : operating mode of the register chain, sampled every clock edge.
package shift_reg_pkg;

   typedef enum logic [1:0] {
      SM_HOLD     = 2'b00,  // keep every stage as it is
      SM_SHIFT_UP = 2'b01,  // stage[i] <= stage[i-1], din_up enters stage 0
      SM_SHIFT_DN = 2'b10,  // stage[i] <= stage[i+1], din_dn enters stage DEPTH-1
      SM_LOAD     = 2'b11   // all stages loaded from par_in / par_vld at once
   } shift_mode_e;

endpackage

// File: rtl/shift_reg_pipe_if.sv
// Bus bundle for shift_reg_pipe.
//   master : the user of the shift register (drives mode, flush, serial and
//            parallel inputs; observes outputs)
//   slave  : the shift register itself
// There is no backpressure: whatever mode/flush/data is present on a rising
// clock edge is consumed on that edge, and every output is a register tap
// (or a function of register taps) valid for the whole following cycle.
interface shift_reg_pipe_if
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   shift_mode_e              mode;
   logic                     flush;
   logic [WIDTH-1:0]         din_up;
   logic                     din_up_vld;
   logic [WIDTH-1:0]         din_dn;
   logic                     din_dn_vld;
   logic [DEPTH*WIDTH-1:0]   par_in;
   logic [DEPTH-1:0]         par_vld;

   logic [WIDTH-1:0]         dout_up;
   logic [WIDTH-1:0]         dout_dn;
   logic [DEPTH*WIDTH-1:0]   par_out;
   logic [DEPTH-1:0]         vld_vec;
   logic [CNT_W-1:0]         fill_cnt;
   logic                     full;
   logic                     empty;

   modport master (
      output mode, flush, din_up, din_up_vld, din_dn, din_dn_vld, par_in, par_vld,
      input  dout_up, dout_dn, par_out, vld_vec, fill_cnt, full, empty
   );

   modport slave (
      input  mode, flush, din_up, din_up_vld, din_dn, din_dn_vld, par_in, par_vld,
      output dout_up, dout_dn, par_out, vld_vec, fill_cnt, full, empty
   );

endinterface

// File: rtl/shift_reg_stage.sv
// One stage of the shift register: a WIDTH-bit data flop plus its valid flop.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   flush             clears the valid flop only; data holds
//   mode              selects the next value source
//   d_below/v_below   neighbour towards stage 0 (used by SHIFT_UP)
//   d_above/v_above   neighbour towards stage DEPTH-1 (used by SHIFT_DN)
//   d_par/v_par       this stage's parallel-load slice (used by LOAD)
//   q/v               registered data and valid
module shift_reg_stage
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  shift_mode_e      mode,
   input  logic [WIDTH-1:0] d_below,
   input  logic             v_below,
   input  logic [WIDTH-1:0] d_above,
   input  logic             v_above,
   input  logic [WIDTH-1:0] d_par,
   input  logic             v_par,
   output logic [WIDTH-1:0] q,
   output logic             v
);

   always_ff @(posedge clock) begin
      if (reset) begin
         q <= RESET_VAL;
         v <= 1'b0;
      end else if (flush) begin
         // Flush wins over any mode: occupancy drops, data is left as is.
         v <= 1'b0;
      end else begin
         case (mode)
            SM_SHIFT_UP: begin
               q <= d_below;
               v <= v_below;
            end
            SM_SHIFT_DN: begin
               q <= d_above;
               v <= v_above;
            end
            SM_LOAD: begin
               q <= d_par;
               v <= v_par;
            end
            default: ;  // HOLD, and an unknown mode degrades to HOLD
         endcase
      end
   end

endmodule

// File: rtl/shift_reg_pipe.sv
// Parametrised multi-bit shift register with per-stage valid tags.
// Parameters: WIDTH bits per stage, DEPTH stages, RESET_VAL reset content.
// The interface instance must be built with the same WIDTH and DEPTH.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   bus (slave)    mode/flush/serial/parallel inputs; dout_up (stage DEPTH-1),
//                  dout_dn (stage 0), par_out, vld_vec, fill_cnt, full, empty
// All outputs come from registers only; nothing on the bus inputs reaches an
// output combinationally.
module shift_reg_pipe
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic             clock,
   input logic             reset,
   shift_reg_pipe_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   // Unpacked so each element is a separate flop output in the chain.
   logic [WIDTH-1:0] stage_q [DEPTH];
   logic             stage_v [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic [WIDTH-1:0] d_below;
      logic             v_below;
      logic [WIDTH-1:0] d_above;
      logic             v_above;

      // Chain ends take the serial inputs; inner stages take their neighbours.
      if (g == 0) begin : g_lo_end
         assign d_below = bus.din_up;
         assign v_below = bus.din_up_vld;
      end else begin : g_lo_chain
         assign d_below = stage_q[g-1];
         assign v_below = stage_v[g-1];
      end

      if (g == DEPTH - 1) begin : g_hi_end
         assign d_above = bus.din_dn;
         assign v_above = bus.din_dn_vld;
      end else begin : g_hi_chain
         assign d_above = stage_q[g+1];
         assign v_above = stage_v[g+1];
      end

      shift_reg_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clock   (clock),
         .reset   (reset),
         .flush   (bus.flush),
         .mode    (bus.mode),
         .d_below (d_below),
         .v_below (v_below),
         .d_above (d_above),
         .v_above (v_above),
         .d_par   (bus.par_in[g*WIDTH +: WIDTH]),
         .v_par   (bus.par_vld[g]),
         .q       (stage_q[g]),
         .v       (stage_v[g])
      );

      assign bus.par_out[g*WIDTH +: WIDTH] = stage_q[g];
      assign bus.vld_vec[g]                = stage_v[g];
   end

   assign bus.dout_up = stage_q[DEPTH-1];
   assign bus.dout_dn = stage_q[0];

   // Status is derived from the valid bits alone; data content never matters.
   logic [CNT_W-1:0] cnt;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt = cnt + CNT_W'(bus.vld_vec[i]);
      end
   end

   assign bus.fill_cnt = cnt;
   assign bus.full     = &bus.vld_vec;
   assign bus.empty    = ~|bus.vld_vec;

   // An X on mode would be silently treated as HOLD in hardware; flag it in simulation.
   a_mode_known : assert property (@(posedge clock) disable iff (reset) !$isunknown(bus.mode));

endmodule

// File: tb/tb_shift_reg_pipe.sv
module tb_shift_reg_pipe;
   import shift_reg_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   shift_reg_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   shift_reg_pipe #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .RESET_VAL (RESET_VAL)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   // ---------------- scoreboard / reference model ----------------
   // exp_q[i] is the expected content of stage i; vld_q[i] its valid tag.
   // The register is modelled as a fixed-length queue: shifting up pushes at
   // the front and drops the back, shifting down does the reverse.
   logic [WIDTH-1:0] exp_q[$];
   logic             vld_q[$];
   int               vec_cnt = 0;
   int               err_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         exp_q.delete();
         vld_q.delete();
         for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(RESET_VAL);
            vld_q.push_back(1'b0);
         end
      end else if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) vld_q[i] = 1'b0;
      end else begin
         case (bus.mode)
            SM_SHIFT_UP: begin
               exp_q.push_front(bus.din_up);
               vld_q.push_front(bus.din_up_vld);
               void'(exp_q.pop_back());
               void'(vld_q.pop_back());
            end
            SM_SHIFT_DN: begin
               exp_q.push_back(bus.din_dn);
               vld_q.push_back(bus.din_dn_vld);
               void'(exp_q.pop_front());
               void'(vld_q.pop_front());
            end
            SM_LOAD: begin
               for (int i = 0; i < DEPTH; i++) begin
                  exp_q[i] = bus.par_in[i*WIDTH +: WIDTH];
                  vld_q[i] = bus.par_vld[i];
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_all();
      logic [DEPTH*WIDTH-1:0] ep;
      logic [DEPTH-1:0]       ev;
      int                     n;
      n = 0;
      for (int i = 0; i < DEPTH; i++) begin
         ep[i*WIDTH +: WIDTH] = exp_q[i];
         ev[i]                = vld_q[i];
         if (vld_q[i]) n++;
      end
      check("par_out",  64'(bus.par_out),  64'(ep));
      check("vld_vec",  64'(bus.vld_vec),  64'(ev));
      check("dout_up",  64'(bus.dout_up),  64'(exp_q[DEPTH-1]));
      check("dout_dn",  64'(bus.dout_dn),  64'(exp_q[0]));
      check("fill_cnt", 64'(bus.fill_cnt), 64'(n));
      check("full",     64'(bus.full),     64'(n == DEPTH));
      check("empty",    64'(bus.empty),    64'(n == 0));
   endtask

   // ---------------- driver ----------------
   // Inputs are set 1 time unit after an edge and stay put until the next one.
   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      bus.mode       = SM_HOLD;
      bus.flush      = 1'b0;
      bus.din_up     = '0;
      bus.din_up_vld = 1'b0;
      bus.din_dn     = '0;
      bus.din_dn_vld = 1'b0;
      bus.par_in     = '0;
      bus.par_vld    = '0;
   endtask

   logic [WIDTH-1:0] t2_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      idle_inputs();
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back(RESET_VAL);
         vld_q.push_back(1'b0);
      end

      // 1: reset for two cycles
      reset = 1'b1;
      step();
      step();
      check("t1_par_out", 64'(bus.par_out), 64'h0);
      check("t1_vld_vec", 64'(bus.vld_vec), 64'h0);
      check("t1_empty",   64'(bus.empty),   64'h1);
      check("t1_fill",    64'(bus.fill_cnt), 64'h0);
      reset = 1'b0;

      // 2: four shift-up edges fill the register
      bus.mode       = SM_SHIFT_UP;
      bus.din_up_vld = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.din_up = t2_vals[k];
         step();
      end
      check("t2_dout_up", 64'(bus.dout_up), 64'h11);
      check("t2_par_out", 64'(bus.par_out), 64'h11223344);
      check("t2_full",    64'(bus.full),    64'h1);

      // 3: one shift-down edge with an invalid entry
      bus.mode       = SM_SHIFT_DN;
      bus.din_dn     = 8'hAA;
      bus.din_dn_vld = 1'b0;
      step();
      check("t3_par_out", 64'(bus.par_out),  64'hAA112233);
      check("t3_vld_vec", 64'(bus.vld_vec),  64'h7);
      check("t3_fill",    64'(bus.fill_cnt), 64'h3);

      // 4: parallel load, then hold
      bus.mode    = SM_LOAD;
      bus.par_in  = 32'hDEADBEEF;
      bus.par_vld = 4'b1010;
      step();
      bus.mode    = SM_HOLD;
      bus.par_in  = 32'h0;
      bus.par_vld = 4'b0000;
      repeat (3) step();
      check("t4_par_out", 64'(bus.par_out),  64'hDEADBEEF);
      check("t4_vld_vec", 64'(bus.vld_vec),  64'hA);
      check("t4_fill",    64'(bus.fill_cnt), 64'h2);

      // 5: flush beats LOAD; data untouched
      bus.flush   = 1'b1;
      bus.mode    = SM_LOAD;
      bus.par_in  = 32'h12345678;
      bus.par_vld = 4'b1111;
      step();
      idle_inputs();
      check("t5_vld_vec", 64'(bus.vld_vec), 64'h0);
      check("t5_par_out", 64'(bus.par_out), 64'hDEADBEEF);
      check("t5_empty",   64'(bus.empty),   64'h1);

      // 6: reset in the middle of a shift-up stream
      bus.mode       = SM_SHIFT_UP;
      bus.din_up_vld = 1'b1;
      bus.din_up     = 8'h77;
      step();
      bus.din_up     = 8'h66;
      step();
      reset          = 1'b1;
      bus.din_up     = 8'h55;
      step();
      check("t6_par_out", 64'(bus.par_out), 64'h0);
      check("t6_vld_vec", 64'(bus.vld_vec), 64'h0);
      reset          = 1'b0;
      bus.din_up     = 8'h5A;
      step();
      check("t6_dout_dn", 64'(bus.dout_dn), 64'h5A);
      check("t6_vld_vec2", 64'(bus.vld_vec), 64'h1);

      // Random phase: any mode on any cycle, occasional flush and reset.
      for (int n = 0; n < 500; n++) begin
         bus.mode       = shift_mode_e'($urandom_range(0, 3));
         bus.flush      = ($urandom_range(0, 15) == 0);
         reset          = ($urandom_range(0, 39) == 0);
         bus.din_up     = WIDTH'($urandom);
         bus.din_up_vld = 1'($urandom_range(0, 1));
         bus.din_dn     = WIDTH'($urandom);
         bus.din_dn_vld = 1'($urandom_range(0, 1));
         bus.par_in     = (DEPTH*WIDTH)'($urandom);
         bus.par_vld    = DEPTH'($urandom);
         step();
      end

      reset = 1'b0;
      idle_inputs();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
